// File: rtl/memory_game.sv
// Card-matching game core: generates two rows of four cards, then runs a cursor-driven pick loop.
// Optional MEMORY_SHUFFLE_EN rotates row B by the seed's low two bits.
module memory_game (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic [7:0] SS_in,
  input  logic [7:0] INC_in,
  input  logic       Right,
  input  logic       Left,
  input  logic       Up,
  input  logic       Down,
  input  logic       Select,
  output logic [3:0] Lives,
  output logic [3:0] outA0,
  output logic [3:0] outA1,
  output logic [3:0] outA2,
  output logic [3:0] outA3,
  output logic [3:0] outB0,
  output logic [3:0] outB1,
  output logic [3:0] outB2,
  output logic [3:0] outB3,
  output logic [3:0] outX,
  output logic [3:0] outY,
  output logic [3:0] unos,
  output logic       Qi,
  output logic       Qg,
  output logic       Qfo,
  output logic       Qp,
  output logic       Ql
);

  typedef enum logic [2:0] {StInit, StGen, StFind, StPlay, StLose} state_e;

  state_e          state_q, state_d;
  logic [7:0]      s_q, s_d, inc_q, inc_d;
  logic [1:0]      r_q, r_d, k_q, k_d;
  logic [3:0][3:0] a_q, a_d, b_q, b_d;
  logic [1:0]      x_q, x_d, pick_x_q, pick_x_d;
  logic            y_q, y_d, pick_y_q, pick_y_d;
  logic [3:0]      lives_q, lives_d, unos_q, unos_d, pick_val_q, pick_val_d;
  logic [7:0]      matched_q, matched_d;
  logic [4:0]      btn_q;

  logic [4:0] btn, btn_edge;
  logic       active, sel_e, right_e, left_e, up_e, down_e;
  logic [2:0] cur_idx, pick_idx;
  logic [3:0] cur_val;
  logic       cur_matched, pick_ok, try_pick, is_match, all_done, win;
  logic [7:0] gen_sum, pair_bits;

  assign btn      = {Select, Right, Left, Up, Down};
  assign btn_edge = btn & ~btn_q;
  assign active   = (state_q == StPlay) || (state_q == StFind);
  assign sel_e    = active & btn_edge[4];
  assign right_e  = active & btn_edge[3];
  assign left_e   = active & btn_edge[2];
  assign up_e     = active & btn_edge[1];
  assign down_e   = active & btn_edge[0];

  assign cur_idx     = {y_q, x_q};
  assign pick_idx    = {pick_y_q, pick_x_q};
  assign cur_val     = y_q ? b_q[x_q] : a_q[x_q];
  assign cur_matched = matched_q[cur_idx];
  assign pick_ok     = (state_q == StPlay) && sel_e && !cur_matched;
  assign try_pick    = (state_q == StFind) && sel_e && !cur_matched;
  // Re-selecting the first pick fails the row test, so it is a mismatch.
  assign is_match    = (y_q != pick_y_q) && (cur_val == pick_val_q);
  assign pair_bits   = (8'd1 << cur_idx) | (8'd1 << pick_idx);
  assign all_done    = (matched_q | pair_bits) == 8'hFF;
  assign win         = try_pick && is_match && all_done;
  assign gen_sum     = s_q + 8'(k_q) * inc_q;

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= StInit;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: if (Start) state_d = StGen;
      StGen:  if (k_q == 2'd3) state_d = StPlay;
      StPlay: if (pick_ok) state_d = StFind;
      StFind: begin
        if (try_pick) begin
          if (is_match)             state_d = all_done ? StGen : StPlay;
          else if (lives_q <= 4'd1) state_d = StLose;
          else                      state_d = StPlay;
        end
      end
      StLose: if (Ack) state_d = StInit;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    Qi  = (state_q == StInit);
    Qg  = (state_q == StGen);
    Qfo = (state_q == StFind);
    Qp  = (state_q == StPlay);
    Ql  = (state_q == StLose);
  end

  always_comb begin
    s_d        = s_q;
    inc_d      = inc_q;
    r_d        = r_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    x_d        = x_q;
    y_d        = y_q;
    lives_d    = lives_q;
    unos_d     = unos_q;
    matched_d  = matched_q;
    pick_x_d   = pick_x_q;
    pick_y_d   = pick_y_q;
    pick_val_d = pick_val_q;

    if ((state_q == StInit) && Start) begin
      s_d     = SS_in;
      inc_d   = INC_in;
`ifdef MEMORY_SHUFFLE_EN
      r_d     = SS_in[1:0];
`else
      r_d     = 2'd0;
`endif
      lives_d = 4'd3;
    end

    if (state_q == StGen) begin
      a_d[k_q]       = gen_sum[3:0];
      b_d[k_q + r_q] = gen_sum[3:0];
      k_d            = k_q + 2'd1;
    end

    if (right_e && !left_e && (x_q != 2'd3)) x_d = x_q + 2'd1;
    if (left_e && !right_e && (x_q != 2'd0)) x_d = x_q - 2'd1;
    if (down_e && !up_e) y_d = 1'b1;
    if (up_e && !down_e) y_d = 1'b0;

    if (pick_ok) begin
      pick_x_d   = x_q;
      pick_y_d   = y_q;
      pick_val_d = cur_val;
    end

    if (try_pick) begin
      if (is_match) begin
        matched_d                          = matched_q | pair_bits;
        unos_d[y_q ? pick_x_q : x_q]       = 1'b1;
        if (all_done) s_d                  = s_q + (inc_q << 2);
      end else begin
        lives_d = (lives_q <= 4'd1) ? 4'd0 : lives_q - 4'd1;
      end
    end

    // Every entry to generation starts a fresh board.
    if (((state_q == StInit) && Start) || win) begin
      k_d       = 2'd0;
      x_d       = 2'd0;
      y_d       = 1'b0;
      unos_d    = 4'd0;
      matched_d = 8'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s_q        <= 8'd0;
      inc_q      <= 8'd0;
      r_q        <= 2'd0;
      k_q        <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= 2'd0;
      y_q        <= 1'b0;
      lives_q    <= 4'd3;
      unos_q     <= 4'd0;
      matched_q  <= 8'd0;
      pick_x_q   <= 2'd0;
      pick_y_q   <= 1'b0;
      pick_val_q <= 4'd0;
      btn_q      <= 5'd0;
    end else begin
      s_q        <= s_d;
      inc_q      <= inc_d;
      r_q        <= r_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      x_q        <= x_d;
      y_q        <= y_d;
      lives_q    <= lives_d;
      unos_q     <= unos_d;
      matched_q  <= matched_d;
      pick_x_q   <= pick_x_d;
      pick_y_q   <= pick_y_d;
      pick_val_q <= pick_val_d;
      btn_q      <= btn;
    end
  end

  assign Lives = lives_q;
  assign outA0 = a_q[0];
  assign outA1 = a_q[1];
  assign outA2 = a_q[2];
  assign outA3 = a_q[3];
  assign outB0 = b_q[0];
  assign outB1 = b_q[1];
  assign outB2 = b_q[2];
  assign outB3 = b_q[3];
  assign outX  = {2'b00, x_q};
  assign outY  = {3'b000, y_q};
  assign unos  = unos_q;

endmodule

// File: tb/tb_memory_game.sv
// Scoreboard bench for memory_game: stimulus queues expected fields, a negedge monitor checks them.
module tb_memory_game;

`ifdef MEMORY_SHUFFLE_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  localparam int FState = 0, FLives = 1, FUnos = 2, FX = 3, FY = 4, FA = 5, FB = 6;
  localparam logic [15:0] SIni = 16'b10000, SGen = 16'b01000, SFind = 16'b00100;
  localparam logic [15:0] SPlay = 16'b00010, SLose = 16'b00001;

  logic       Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Ack = 1'b0;
  logic [7:0] SS_in = 8'd0, INC_in = 8'd0;
  logic       Right = 1'b0, Left = 1'b0, Up = 1'b0, Down = 1'b0, Select = 1'b0;
  logic [3:0] Lives, outA0, outA1, outA2, outA3, outB0, outB1, outB2, outB3, outX, outY, unos;
  logic       Qi, Qg, Qfo, Qp, Ql;

  memory_game dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .SS_in(SS_in), .INC_in(INC_in),
    .Right(Right), .Left(Left), .Up(Up), .Down(Down), .Select(Select), .Lives(Lives),
    .outA0(outA0), .outA1(outA1), .outA2(outA2), .outA3(outA3),
    .outB0(outB0), .outB1(outB1), .outB2(outB2), .outB3(outB3),
    .outX(outX), .outY(outY), .unos(unos),
    .Qi(Qi), .Qg(Qg), .Qfo(Qfo), .Qp(Qp), .Ql(Ql)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    int          field;
    logic [15:0] val;
    int          due;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_tests = 0, n_fail = 0;
  int    cx = 0, cy = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [15:0] field_val(int f);
    case (f)
      FState:  return {11'd0, Qi, Qg, Qfo, Qp, Ql};
      FLives:  return {12'd0, Lives};
      FUnos:   return {12'd0, unos};
      FX:      return {12'd0, outX};
      FY:      return {12'd0, outY};
      FA:      return {outA3, outA2, outA1, outA0};
      FB:      return {outB3, outB2, outB1, outB0};
      default: return 16'hFFFF;
    endcase
  endfunction

  // Monitor: every queued item due this cycle is compared against the settled outputs.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      item_t it;
      logic [15:0] got;
      it  = sb.pop_front();
      got = field_val(it.field);
      n_tests++;
      if (got !== it.val) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h (cycle %0d)", it.name, got, it.val, cyc);
      end
    end
  end

  function automatic void chk(string n, int f, logic [15:0] v);
    item_t it;
    it.name  = n;
    it.field = f;
    it.val   = v;
    it.due   = cyc;
    sb.push_back(it);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // m = {Select, Right, Left, Up, Down}; one low cycle, then a one-cycle pulse.
  task automatic press(logic [4:0] m);
    tick(1);
    {Select, Right, Left, Up, Down} = m;
    tick(1);
    {Select, Right, Left, Up, Down} = 5'd0;
  endtask

  task automatic goto_pos(int tx, int ty);
    while (cx < tx) begin press(5'b01000); cx++; end
    while (cx > tx) begin press(5'b00100); cx--; end
    if (ty > cy) press(5'b00001);
    if (ty < cy) press(5'b00010);
    cy = ty;
  endtask

  task automatic sel_at(int tx, int ty);
    goto_pos(tx, ty);
    press(5'b10000);
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    cx = 0;
    cy = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("reset_state", FState, SIni);
    chk("reset_lives", FLives, 16'd3);
    chk("reset_unos", FUnos, 16'd0);
    chk("reset_x", FX, 16'd0);
    chk("reset_a", FA, 16'h0000);
    chk("reset_b", FB, 16'h0000);
    Reset = 1'b1;
    SS_in = 8'd1;
    INC_in = 8'd1;
    tick(1);

    // Generation: Qg for four cycles, Qp on the fifth.
    do_start();
    chk("gen_enter", FState, SGen);
    tick(3);
    chk("gen_last", FState, SGen);
    tick(1);
    chk("gen_done", FState, SPlay);
    chk("gen_a", FA, 16'h4321);
    chk("gen_b", FB, (R == 1) ? 16'h3214 : 16'h4321);
    chk("gen_lives", FLives, 16'd3);

    // Cursor saturation at the origin.
    press(5'b00100);
    chk("left_sat", FX, 16'd0);
    press(5'b00010);
    chk("up_sat", FY, 16'd0);

    // Match A0 with its partner in row B.
    sel_at(0, 0);
    chk("pick1_state", FState, SFind);
    sel_at((0 + R) % 4, 1);
    chk("match_state", FState, SPlay);
    chk("match_unos", FUnos, 16'b0001);
    chk("match_lives", FLives, 16'd3);

    // A matched card cannot be picked again.
    sel_at(0, 0);
    chk("matched_ignored", FState, SPlay);

    // Select with Right in one cycle picks the pre-move card (A1=2), then A2=3 mismatches.
    goto_pos(1, 0);
    press(5'b11000);
    cx = 2;
    chk("combo_state", FState, SFind);
    chk("combo_x", FX, 16'd2);
    press(5'b10000);
    chk("mismatch_lives", FLives, 16'd2);
    chk("mismatch_unos", FUnos, 16'b0001);
    chk("mismatch_state", FState, SPlay);

    // Right saturates at column 3.
    goto_pos(3, 0);
    press(5'b01000);
    chk("right_sat", FX, 16'd3);

    // Clear the remaining pairs; the last one starts a new round.
    for (int k = 1; k < 4; k++) begin
      sel_at(k, 0);
      sel_at((k + R) % 4, 1);
    end
    cx = 0;
    cy = 0;
    chk("win_state", FState, SGen);
    chk("win_unos", FUnos, 16'd0);
    chk("win_x", FX, 16'd0);
    chk("win_y", FY, 16'd0);
    tick(3);
    chk("round2_gen", FState, SGen);
    tick(1);
    chk("round2_play", FState, SPlay);
    chk("round2_a", FA, 16'h8765);
    chk("round2_b", FB, (R == 1) ? 16'h7658 : 16'h8765);
    chk("round2_lives", FLives, 16'd2);

    // Lose: same card twice, then two different row-A cards.
    sel_at(0, 0);
    sel_at(0, 0);
    chk("self_pick_lives", FLives, 16'd1);
    chk("self_pick_state", FState, SPlay);
    sel_at(1, 0);
    sel_at(2, 0);
    chk("lose_state", FState, SLose);
    chk("lose_lives", FLives, 16'd0);
    Start = 1'b1;
    tick(3);
    Start = 1'b0;
    chk("lose_hold", FState, SLose);
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    chk("ack_state", FState, SIni);
    tick(1);
    do_start();
    chk("restart_lives", FLives, 16'd3);
    tick(4);
    chk("restart_play", FState, SPlay);

    // Reset in the middle of a pick.
    sel_at(1, 1);
    chk("prereset_state", FState, SFind);
    Reset = 1'b0;
    tick(1);
    chk("rst_state", FState, SIni);
    chk("rst_lives", FLives, 16'd3);
    chk("rst_x", FX, 16'd0);
    chk("rst_y", FY, 16'd0);
    chk("rst_a", FA, 16'h0000);
    chk("rst_b", FB, 16'h0000);
    Reset = 1'b1;
    cx = 0;
    cy = 0;

    tick(2);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
